// File: rtl/wavegen_pkg.sv
// Shared types and widths for the square-wave DAC sequencer.
// DATA_W  : DAC sample width
// DIV_W   : half-period counter width (clock cycles)
// BURST_W : burst length width (full periods, 0 = continuous)
package wavegen_pkg;

  localparam int DATA_W  = 14;
  localparam int DIV_W   = 16;
  localparam int BURST_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0]  amp;
    logic [DIV_W-1:0]   half;
    logic [BURST_W-1:0] burst;
  } cfg_t;

  // A programmed half-period of 0 behaves like 1 so the counter never underflows.
  function automatic logic [DIV_W-1:0] half_eff(input logic [DIV_W-1:0] half);
    return (half == '0) ? DIV_W'(1) : half;
  endfunction

endpackage

// File: rtl/wavegen_sequencer_rr_arbiter2.sv
// Two-requester round-robin arbiter.
// clk_i/rst_i : clock, synchronous active-high reset
// en_i        : arbitration allowed this cycle (grants forced low otherwise)
// req_i[1:0]  : request vector
// gnt_o[1:0]  : one-hot (or zero) grant, combinational
// The priority pointer moves to the other requester after every grant,
// so every grant is treated as a completed transfer.
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;  // 0: Req0 preferred, 1: Req1 preferred

  // NOTE: every signal driven in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt_o = 2'b00;
    ptr_d = ptr_q;
    if (en_i) begin
      if (req_i == 2'b11) gnt_o = ptr_q ? 2'b10 : 2'b01;
      else                gnt_o = req_i;
    end
    if (gnt_o[0])      ptr_d = 1'b1;
    else if (gnt_o[1]) ptr_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/wavegen_sequencer.sv
// Square-wave DAC burst sequencer.
// clk_i, rst_i            : 50 MHz clock, synchronous active-high reset
// reqN_valid_i/ready_o    : config handshake from host (0) and auto-cal (1)
// reqN_amp/half/burst_i   : high level, half-period in cycles, period count
// abort_i                 : stop the current burst immediately
// signal_out_o            : registered DAC sample
// busy_o, burst_done_o    : registered activity flag and completion pulse
// grant_id_o              : requester of the active/last accepted config
module wavegen_sequencer
  import wavegen_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req0_valid_i,
  output logic               req0_ready_o,
  input  logic [DATA_W-1:0]  req0_amp_i,
  input  logic [DIV_W-1:0]   req0_half_i,
  input  logic [BURST_W-1:0] req0_burst_i,
  input  logic               req1_valid_i,
  output logic               req1_ready_o,
  input  logic [DATA_W-1:0]  req1_amp_i,
  input  logic [DIV_W-1:0]   req1_half_i,
  input  logic [BURST_W-1:0] req1_burst_i,
  input  logic               abort_i,
  output logic [DATA_W-1:0]  signal_out_o,
  output logic               busy_o,
  output logic               burst_done_o,
  output logic               grant_id_o
);

  state_e             state_q, state_d;
  cfg_t               cfg_q, cfg_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0]  sig_q, sig_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               gid_q, gid_d;
  logic [1:0]         gnt;

  rr_arbiter2 u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  ((state_q == ST_IDLE) && !abort_i),
    .req_i ({req1_valid_i, req0_valid_i}),
    .gnt_o (gnt)
  );

  assign req0_ready_o = gnt[0];
  assign req1_ready_o = gnt[1];

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    gid_d   = gid_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          cfg_d.amp   = gnt[1] ? req1_amp_i   : req0_amp_i;
          cfg_d.half  = half_eff(gnt[1] ? req1_half_i : req0_half_i);
          cfg_d.burst = gnt[1] ? req1_burst_i : req0_burst_i;
          gid_d       = gnt[1];
          state_d     = ST_HIGH;
          cnt_d       = cfg_d.half - DIV_W'(1);
          rem_d       = cfg_d.burst;
        end
      end
      ST_HIGH: begin
        if (cnt_q == '0) begin
          state_d = ST_LOW;
          cnt_d   = cfg_q.half - DIV_W'(1);
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      ST_LOW: begin
        if (cnt_q == '0) begin
          if (cfg_q.burst == '0) begin
            state_d = ST_HIGH;  // continuous mode never counts periods
            cnt_d   = cfg_q.half - DIV_W'(1);
          end else if (rem_q == BURST_W'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_HIGH;
            rem_d   = rem_q - BURST_W'(1);
            cnt_d   = cfg_q.half - DIV_W'(1);
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides everything; the arbiter is already disabled, so no accept happens.
    if (abort_i) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
    end

    // Outputs are registered from the next state so they line up with it.
    sig_d  = (state_d == ST_HIGH) ? cfg_d.amp : '0;
    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: the working config registers are reset too, so a reset discards any in-flight burst configuration.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cfg_q   <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      sig_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      sig_q   <= sig_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      gid_q   <= gid_d;
    end
  end

  assign signal_out_o = sig_q;
  assign busy_o       = busy_q;
  assign burst_done_o = done_q;
  assign grant_id_o   = gid_q;

endmodule

// File: tb/tb_wavegen_sequencer.sv
// Directed self-checking bench for wavegen_sequencer.
module tb_wavegen_sequencer;
  import wavegen_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               req0_valid, req1_valid, req0_ready, req1_ready;
  logic [DATA_W-1:0]  req0_amp, req1_amp, sig;
  logic [DIV_W-1:0]   req0_half, req1_half;
  logic [BURST_W-1:0] req0_burst, req1_burst;
  logic               abort, busy, done, gid;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] exp1 [6] = '{14'h0FFF, 14'h0, 14'h0FFF, 14'h0, 14'h0FFF, 14'h0};
  logic [DATA_W-1:0] exp3 [4] = '{14'h1234, 14'h0, 14'h1234, 14'h0};

  always #10 clk = ~clk;

  wavegen_sequencer dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req0_valid_i (req0_valid),
    .req0_ready_o (req0_ready),
    .req0_amp_i   (req0_amp),
    .req0_half_i  (req0_half),
    .req0_burst_i (req0_burst),
    .req1_valid_i (req1_valid),
    .req1_ready_o (req1_ready),
    .req1_amp_i   (req1_amp),
    .req1_half_i  (req1_half),
    .req1_burst_i (req1_burst),
    .abort_i      (abort),
    .signal_out_o (sig),
    .busy_o       (busy),
    .burst_done_o (done),
    .grant_id_o   (gid)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string tag, input logic [31:0] s, input logic b, input logic d);
    check({tag, "_sig"},  32'(sig),  s);
    check({tag, "_busy"}, 32'(busy), 32'(b));
    check({tag, "_done"}, 32'(done), 32'(d));
  endtask

  initial begin
    rst = 1'b1; abort = 1'b0;
    req0_valid = 1'b0; req0_amp = '0; req0_half = '0; req0_burst = '0;
    req1_valid = 1'b0; req1_amp = '0; req1_half = '0; req1_burst = '0;
    tick(); tick();

    // Reset state
    outs("rst", 0, 1'b0, 1'b0);
    check("rst_gid", 32'(gid), 0);
    rst = 1'b0;
    #1;
    check("rst_ready0_idle", 32'(req0_ready), 0);

    // Test 1: single Req0, Half=1, Burst=3
    req0_valid = 1'b1; req0_amp = 14'h0FFF; req0_half = 16'd1; req0_burst = 8'd3;
    #1;
    check("t1_ready0", 32'(req0_ready), 1);
    check("t1_ready1", 32'(req1_ready), 0);
    tick();
    req0_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      outs($sformatf("t1_c%0d", i + 1), 32'(exp1[i]), 1'b1, 1'b0);
      tick();
    end
    outs("t1_donecyc", 0, 1'b0, 1'b1);
    tick();
    check("t1_done_clear", 32'(done), 0);

    // Test 2: simultaneous requesters, round robin from a fresh pointer
    rst = 1'b1; tick(); rst = 1'b0;
    req0_valid = 1'b1; req0_amp = 14'h0AAA; req0_half = 16'd2; req0_burst = 8'd1;
    req1_valid = 1'b1; req1_amp = 14'h0555; req1_half = 16'd2; req1_burst = 8'd1;
    #1;
    check("t2_ready0", 32'(req0_ready), 1);
    check("t2_ready1", 32'(req1_ready), 0);
    tick();
    check("t2_gid0", 32'(gid), 0);
    check("t2_busy_ready0", 32'(req0_ready), 0);
    check("t2_busy_ready1", 32'(req1_ready), 0);
    outs("t2_c1", 32'h0AAA, 1'b1, 1'b0);
    tick(); outs("t2_c2", 32'h0AAA, 1'b1, 1'b0);
    tick(); outs("t2_c3", 0, 1'b1, 1'b0);
    tick(); outs("t2_c4", 0, 1'b1, 1'b0);
    tick(); outs("t2_c5", 0, 1'b0, 1'b1);
    check("t2_rr_ready1", 32'(req1_ready), 1);
    check("t2_rr_ready0", 32'(req0_ready), 0);
    tick();
    check("t2_gid1", 32'(gid), 1);
    outs("t2_r1_c1", 32'h0555, 1'b1, 1'b0);
    tick(); tick(); tick(); tick();
    check("t2_r1_done", 32'(done), 1);
    check("t2_third_ready0", 32'(req0_ready), 1);
    check("t2_third_ready1", 32'(req1_ready), 0);
    tick();
    check("t2_third_gid", 32'(gid), 0);
    check("t2_third_sig", 32'(sig), 32'h0AAA);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick(); tick(); tick(); tick();
    check("t2_third_done", 32'(done), 1);

    // Test 3: Half=0 behaves as Half=1
    req1_valid = 1'b1; req1_amp = 14'h1234; req1_half = 16'd0; req1_burst = 8'd2;
    #1;
    check("t3_ready1", 32'(req1_ready), 1);
    tick();
    req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      outs($sformatf("t3_c%0d", i + 1), 32'(exp3[i]), 1'b1, 1'b0);
      tick();
    end
    outs("t3_donecyc", 0, 1'b0, 1'b1);
    tick();

    // Test 4: continuous Half=4 for 100 cycles, then abort
    req0_valid = 1'b1; req0_amp = 14'h2000; req0_half = 16'd4; req0_burst = 8'd0;
    tick();
    req0_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      outs($sformatf("t4_c%0d", i + 1), ((i / 4) % 2 == 0) ? 32'h2000 : 32'h0, 1'b1, 1'b0);
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    outs("t4_abort", 0, 1'b0, 1'b0);
    tick();
    outs("t4_after_abort", 0, 1'b0, 1'b0);

    // Test 5: abort in IDLE blocks the grant
    abort = 1'b1;
    req1_valid = 1'b1; req1_amp = 14'h1111; req1_half = 16'd1; req1_burst = 8'd1;
    #1;
    check("t5_ready1_blocked", 32'(req1_ready), 0);
    check("t5_ready0_blocked", 32'(req0_ready), 0);
    tick();
    outs("t5_idle", 0, 1'b0, 1'b0);
    abort = 1'b0;
    #1;
    check("t5_ready1_after", 32'(req1_ready), 1);
    req1_valid = 1'b0;

    // Test 6: reset mid-HIGH of a Burst=5 config
    req0_valid = 1'b1; req0_amp = 14'h3333; req0_half = 16'd8; req0_burst = 8'd5;
    tick();
    req0_valid = 1'b0;
    outs("t6_start", 32'h3333, 1'b1, 1'b0);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    outs("t6_rst", 0, 1'b0, 1'b0);
    check("t6_rst_gid", 32'(gid), 0);
    req0_valid = 1'b1; req0_amp = 14'h0AAA; req0_half = 16'd1; req0_burst = 8'd1;
    req1_valid = 1'b1;
    #1;
    check("t6_ptr_ready0", 32'(req0_ready), 1);
    check("t6_ptr_ready1", 32'(req1_ready), 0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("t6_new_gid", 32'(gid), 0);
    outs("t6_new", 32'h0AAA, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
